// File: rtl/nl_layer_ctrl.sv
// Sequencer for the nonlinearity layer: validates a shadowed configuration, streams
// input-buffer reads into the fixed-latency datapath and emits matching output writes.
module nl_layer_ctrl #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] IN_BASE  = 16'h0000,
   parameter logic [ADDR_W-1:0] OUT_BASE = 16'h8000,
   parameter int                PIPE_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic [15:0]       cfg_data_wid,
   input  logic [15:0]       cfg_data_hei,
   input  logic [15:0]       cfg_data_ch,
   input  logic [15:0]       cfg_nl_type,
   input  logic [15:0]       cfg_input_data_length,
   output logic [1:0]        nl_mode,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       output_wid,
   output logic [15:0]       output_hei,
   output logic [15:0]       output_ch,
   output logic [15:0]       output_data_length,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

   localparam logic [PIPE_LAT-1:0] TOP_BIT = PIPE_LAT'(1) << (PIPE_LAT - 1);
   localparam logic [ADDR_W:0]     CNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [47:0]         N_MAX   = 48'd1 << (ADDR_W - 1);

   state_t            state_q, state_d;
   logic [15:0]       wid_q, wid_d, hei_q, hei_d, ch_q, ch_d, type_q, type_d, len_q, len_d;
   logic [15:0]       owid_q, owid_d, ohei_q, ohei_d, och_q, och_d, olen_q, olen_d;
   logic [ADDR_W:0]   cnt_q, cnt_d, n_q, n_d;
   logic [1:0]        mode_q, mode_d;
   logic              err_q, err_d;
   logic [PIPE_LAT-1:0] vld_q;
   logic [ADDR_W-1:0] off_q [PIPE_LAT];

   logic [47:0]       n_full;
   logic              cfg_bad;
   logic              rd_go;

   always_comb begin
      n_full  = 48'(wid_q) * 48'(hei_q) * 48'(ch_q);
      cfg_bad = (wid_q == '0) || (hei_q == '0) || (ch_q == '0) ||
                (n_full != 48'(len_q)) || (type_q[15:2] != '0) ||
                (type_q[1:0] == 2'd3) || (n_full > N_MAX);
   end

   always_comb begin
      state_d = state_q;
      wid_d   = wid_q;
      hei_d   = hei_q;
      ch_d    = ch_q;
      type_d  = type_q;
      len_d   = len_q;
      owid_d  = owid_q;
      ohei_d  = ohei_q;
      och_d   = och_q;
      olen_d  = olen_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      mode_d  = mode_q;
      err_d   = err_q;
      rd_go   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               wid_d   = cfg_data_wid;
               hei_d   = cfg_data_hei;
               ch_d    = cfg_data_ch;
               type_d  = cfg_nl_type;
               len_d   = cfg_input_data_length;
               err_d   = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (cfg_bad) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               mode_d  = type_q[1:0];
               n_d     = n_full[ADDR_W:0];
               cnt_d   = '0;
               owid_d  = wid_q;
               ohei_d  = hei_q;
               och_d   = ch_q;
               olen_d  = len_q;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // pause gates the read in the same cycle; cnt never exceeds n_q here
            if (!pause) begin
               rd_go = 1'b1;
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q + CNT_ONE == n_q) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // only the entry leaving this cycle may remain in the delay line
            if ((vld_q & ~TOP_BIT) == '0) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wid_q   <= '0;
         hei_q   <= '0;
         ch_q    <= '0;
         type_q  <= '0;
         len_q   <= '0;
         owid_q  <= '0;
         ohei_q  <= '0;
         och_q   <= '0;
         olen_q  <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         mode_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wid_q   <= wid_d;
         hei_q   <= hei_d;
         ch_q    <= ch_d;
         type_q  <= type_d;
         len_q   <= len_d;
         owid_q  <= owid_d;
         ohei_q  <= ohei_d;
         och_q   <= och_d;
         olen_q  <= olen_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < PIPE_LAT; i++) off_q[i] <= '0;
      end else begin
         vld_q[0] <= rd_go;
         off_q[0] <= cnt_q[ADDR_W-1:0];
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            off_q[i] <= off_q[i-1];
         end
      end
   end

   assign rd_en              = rd_go;
   assign rd_addr            = rd_go ? (IN_BASE + cnt_q[ADDR_W-1:0]) : '0;
   assign wr_en              = vld_q[PIPE_LAT-1];
   assign wr_addr            = wr_en ? (OUT_BASE + off_q[PIPE_LAT-1]) : '0;
   assign nl_mode            = mode_q;
   assign output_wid         = owid_q;
   assign output_hei         = ohei_q;
   assign output_ch          = och_q;
   assign output_data_length = olen_q;
   assign busy               = (state_q == S_CHECK) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done               = (state_q == S_DONE);
   assign err                = err_q;

endmodule

// File: tb/tb_nl_layer_ctrl.sv
// Bench for nl_layer_ctrl: table of jobs plus random jobs, each compared against a
// cycle-stamped model of the expected read/write/done trace.
module tb_nl_layer_ctrl;

   localparam int          ADDR_W   = 16;
   localparam logic [15:0] IN_BASE  = 16'h0000;
   localparam logic [15:0] OUT_BASE = 16'h8000;
   localparam int          PIPE_LAT = 3;

   logic        clk = 1'b0;
   logic        rst, start, pause;
   logic [15:0] cfg_data_wid, cfg_data_hei, cfg_data_ch, cfg_nl_type, cfg_input_data_length;
   logic [1:0]  nl_mode;
   logic        rd_en, wr_en, busy, done, err;
   logic [15:0] rd_addr, wr_addr;
   logic [15:0] output_wid, output_hei, output_ch, output_data_length;

   nl_layer_ctrl #(
      .ADDR_W(ADDR_W), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause),
      .cfg_data_wid(cfg_data_wid), .cfg_data_hei(cfg_data_hei), .cfg_data_ch(cfg_data_ch),
      .cfg_nl_type(cfg_nl_type), .cfg_input_data_length(cfg_input_data_length),
      .nl_mode(nl_mode), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
      .output_wid(output_wid), .output_hei(output_hei), .output_ch(output_ch),
      .output_data_length(output_data_length), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] w, h, c, t, l;
      int          p_lo, p_hi, xs;
      bit          e;
      int          n;
   } vec_t;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_ow = '0, exp_oh = '0, exp_oc = '0, exp_ol = '0;
   logic [1:0]  exp_mode = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic bit model_err(input int w, input int h, input int c, input int t, input int l);
      longint n;
      n = longint'(w) * longint'(h) * longint'(c);
      return (w == 0) || (h == 0) || (c == 0) || (n != longint'(l)) || ((t >> 2) != 0) ||
             ((t & 3) == 3) || (n > (longint'(1) << (ADDR_W - 1)));
   endfunction

   // One job: start in rel 0, pause pattern per rel cycle, optional ignored start at rel xs.
   task automatic run_job(input string nm, input logic [15:0] w, h, c, t, l,
                          input int p_lo, input int p_hi, input bit rnd_pause, input int xs,
                          input bit exp_err, input int exp_n);
      int rd_rel[$], wr_rel[$], done_rel[$], exp_rel[$];
      logic [15:0] rd_adr[$], wr_adr[$];
      bit ph[$], bh[$];
      int rel, stop_rel, err_rel, k, last;
      bit p;
      @(negedge clk);
      cfg_data_wid = w; cfg_data_hei = h; cfg_data_ch = c;
      cfg_nl_type = t; cfg_input_data_length = l;
      start = 1'b1; pause = 1'b0;
      ph.push_back(1'b0);
      #1;
      bh.push_back(busy);
      rel = 0; stop_rel = -1; err_rel = -1;
      while (1) begin
         @(negedge clk);
         rel++;
         start = (rel == xs);
         if (rel == xs) begin
            cfg_data_wid = 16'd9; cfg_data_hei = 16'd9; cfg_data_ch = 16'd9;
            cfg_nl_type = 16'd1; cfg_input_data_length = 16'd81;
         end
         p = rnd_pause ? ($urandom_range(0, 3) == 0) : ((rel - 2 >= p_lo) && (rel - 2 <= p_hi));
         pause = p;
         ph.push_back(p);
         #1;
         bh.push_back(busy);
         if (rel == 1) begin
            chk({nm, "_busy_check"}, 64'(busy), 64'(1));
            chk({nm, "_err_cleared"}, 64'(err), 64'(0));
         end
         if (rd_en) begin rd_rel.push_back(rel); rd_adr.push_back(rd_addr); end
         if (wr_en) begin wr_rel.push_back(rel); wr_adr.push_back(wr_addr); end
         if (done) done_rel.push_back(rel);
         if (err && err_rel < 0) err_rel = rel;
         if (stop_rel < 0 && (done || err)) stop_rel = rel + PIPE_LAT + 3;
         if (rel == stop_rel) break;
         if (rel > 3000) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_done required=done_or_err", nm);
            break;
         end
      end
      start = 1'b0; pause = 1'b0;

      if (exp_err) begin
         chk({nm, "_err_cycle"}, 64'(err_rel), 64'(2));
         chk({nm, "_err_busy"}, 64'(bh[2]), 64'(0));
         chk({nm, "_err_reads"}, 64'(rd_rel.size()), 64'(0));
         chk({nm, "_err_writes"}, 64'(wr_rel.size()), 64'(0));
         chk({nm, "_err_done"}, 64'(done_rel.size()), 64'(0));
         chk({nm, "_err_sticky"}, 64'(err), 64'(1));
      end else begin
         k = 0; last = -1;
         for (int r = 2; r < ph.size() && k < exp_n; r++) begin
            if (!ph[r]) begin exp_rel.push_back(r); k++; last = r; end
         end
         chk({nm, "_n_reads"}, 64'(rd_rel.size()), 64'(exp_n));
         chk({nm, "_n_writes"}, 64'(wr_rel.size()), 64'(exp_n));
         for (int i = 0; i < exp_rel.size(); i++) begin
            if (i < rd_rel.size()) begin
               chk({nm, "_rd_cycle"}, 64'(rd_rel[i]), 64'(exp_rel[i]));
               chk({nm, "_rd_addr"}, 64'(rd_adr[i]), 64'(IN_BASE + 16'(i)));
            end
            if (i < wr_rel.size()) begin
               chk({nm, "_wr_cycle"}, 64'(wr_rel[i]), 64'(exp_rel[i] + PIPE_LAT));
               chk({nm, "_wr_addr"}, 64'(wr_adr[i]), 64'(OUT_BASE + 16'(i)));
            end
         end
         chk({nm, "_done_count"}, 64'(done_rel.size()), 64'(1));
         if (done_rel.size() > 0) begin
            chk({nm, "_done_cycle"}, 64'(done_rel[0]), 64'(last + PIPE_LAT + 1));
            chk({nm, "_done_busy"}, 64'(bh[done_rel[0]]), 64'(0));
         end
         chk({nm, "_no_err"}, 64'(err_rel), 64'(-1));
         exp_ow = w; exp_oh = h; exp_oc = c; exp_ol = l; exp_mode = t[1:0];
      end
      chk({nm, "_out_dims"}, 64'({output_wid, output_hei, output_ch}), 64'({exp_ow, exp_oh, exp_oc}));
      chk({nm, "_out_len"}, 64'(output_data_length), 64'(exp_ol));
      chk({nm, "_nl_mode"}, 64'(nl_mode), 64'(exp_mode));
   endtask

   vec_t tbl[10];
   int   nrd, nwr, guard;

   initial begin
      tbl[0] = '{16'd4,   16'd2,   16'd3, 16'd0,     16'd24,    1,  0, -1, 1'b0, 24};
      tbl[1] = '{16'd4,   16'd2,   16'd3, 16'd0,     16'd24,    5,  9, -1, 1'b0, 24};
      tbl[2] = '{16'd4,   16'd2,   16'd3, 16'd0,     16'd23,    1,  0, -1, 1'b1, 0};
      tbl[3] = '{16'd4,   16'd2,   16'd3, 16'd1,     16'd24,    1,  0, -1, 1'b0, 24};
      tbl[4] = '{16'd4,   16'd2,   16'd3, 16'd3,     16'd24,    1,  0, -1, 1'b1, 0};
      tbl[5] = '{16'd4,   16'd2,   16'd0, 16'd0,     16'd0,     1,  0, -1, 1'b1, 0};
      tbl[6] = '{16'd4,   16'd2,   16'd3, 16'd2,     16'd24,    1,  0,  8, 1'b0, 24};
      tbl[7] = '{16'd1,   16'd1,   16'd1, 16'd2,     16'd1,     1,  0, -1, 1'b0, 1};
      tbl[8] = '{16'd2,   16'd2,   16'd2, 16'h0004,  16'd8,     1,  0, -1, 1'b1, 0};
      tbl[9] = '{16'd200, 16'd200, 16'd1, 16'd0,     16'd40000, 1,  0, -1, 1'b1, 0};

      rst = 1'b0; start = 1'b0; pause = 1'b0;
      cfg_data_wid = '0; cfg_data_hei = '0; cfg_data_ch = '0;
      cfg_nl_type = '0; cfg_input_data_length = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ctrl", 64'({rd_en, rd_addr, wr_en, wr_addr, busy, done, err}), 64'(0));
      chk("reset_cfg_out", 64'({nl_mode, output_wid, output_hei, output_ch}), 64'(0));
      chk("reset_len_out", 64'(output_data_length), 64'(0));
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++)
         run_job($sformatf("tbl%0d", i), tbl[i].w, tbl[i].h, tbl[i].c, tbl[i].t, tbl[i].l,
                 tbl[i].p_lo, tbl[i].p_hi, 1'b0, tbl[i].xs, tbl[i].e, tbl[i].n);

      // asynchronous reset in the middle of a running job
      @(negedge clk);
      cfg_data_wid = 16'd4; cfg_data_hei = 16'd2; cfg_data_ch = 16'd3;
      cfg_nl_type = 16'd0; cfg_input_data_length = 16'd24;
      start = 1'b1; pause = 1'b0;
      @(negedge clk);
      start = 1'b0;
      nrd = 0; guard = 0;
      while (nrd < 10 && guard < 100) begin
         @(negedge clk); #1;
         if (rd_en) nrd++;
         guard++;
      end
      chk("rst_setup_reads", 64'(nrd), 64'(10));
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_async_ctrl", 64'({rd_en, rd_addr, wr_en, wr_addr, busy, done, err}), 64'(0));
      chk("rst_async_cfg", 64'({nl_mode, output_wid, output_hei, output_ch}), 64'(0));
      chk("rst_async_len", 64'(output_data_length), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      nwr = 0; nrd = 0;
      for (int i = 0; i < PIPE_LAT + 4; i++) begin
         @(negedge clk); #1;
         if (wr_en) nwr++;
         if (rd_en) nrd++;
      end
      chk("rst_no_writes", 64'(nwr), 64'(0));
      chk("rst_no_reads", 64'(nrd), 64'(0));
      chk("rst_idle_busy", 64'(busy), 64'(0));
      exp_ow = '0; exp_oh = '0; exp_oc = '0; exp_ol = '0; exp_mode = '0;
      run_job("after_rst", 16'd4, 16'd2, 16'd3, 16'd0, 16'd24, 1, 0, 1'b0, -1, 1'b0, 24);

      for (int j = 0; j < 12; j++) begin
         logic [15:0] w, h, c, t, l;
         int n;
         w = 16'($urandom_range(1, 5));
         h = 16'($urandom_range(1, 5));
         c = 16'($urandom_range(1, 5));
         if ($urandom_range(0, 7) == 0) c = 16'd0;
         n = int'(w) * int'(h) * int'(c);
         l = ($urandom_range(0, 4) == 0) ? 16'(n + 1) : 16'(n);
         t = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) t = t | 16'h0100;
         run_job($sformatf("rnd%0d", j), w, h, c, t, l, 1, 0, 1'b1, -1,
                 model_err(int'(w), int'(h), int'(c), int'(t), int'(l)), n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
